cu_microsequencer: RTL and testbench
====================================

Name: cu_microsequencer

Overview:
Parametrised control-unit state sequencer, the next generation of the CU state counter. It maps an opcode to the first state of its execute routine using a base/stride rule. It also supports increment, absolute jump, return-to-fetch, stall, illegal-opcode trapping and a per-instruction step count. It sits between the decoder/IR and the CU output decode, which is driven from q.

Parameters:
OPCODE_BITS, 3, opcode width
N, 5, state register width
NUM_OPS, 6, number of legal opcodes (0..NUM_OPS-1); requires NUM_OPS <= 2**OPCODE_BITS
FETCH_START, 0, state index of FETCH1
MAP_BASE, 3, start state of opcode 0
MAP_STRIDE, 3, state spacing between consecutive opcode routines
TRAP_STATE, 31, state entered on an illegal opcode

Ports:
clk  in  1  rising-edge clock
clr  in  1  synchronous active-high reset
opcode  in  OPCODE_BITS  opcode from IR, sampled on load
load  in  1  dispatch: jump to mapped start state of opcode
inc  in  1  advance to next state
jmp  in  1  absolute jump to jmp_target
jmp_target  in  N  jump destination
ret  in  1  return to FETCH_START (end of routine)
stall  in  1  freeze all state (memory wait)
q  out  N  current state
opcode_q  out  OPCODE_BITS  registered opcode of the instruction in execution
step  out  N  cycles since last dispatch, saturating
dispatch  out  1  registered pulse, high the cycle after a legal load
illegal  out  1  sticky illegal-opcode flag

Behaviour:
- All registers update on posedge clk only. No combinational path from inputs to outputs; q, opcode_q, step, dispatch and illegal are all registered.
- Reset (clr=1, overrides everything including stall): q=FETCH_START, opcode_q=0, step=0, dispatch=0, illegal=0. A clr in mid-routine abandons the routine next cycle.
- stall=1 (clr=0): q, opcode_q, step and illegal hold. dispatch=0.
- Otherwise the command priority is ret > load > jmp > inc > hold. Exactly one action is taken per cycle.
- ret: q<=FETCH_START; step<=step+1 (saturating).
- load with opcode < NUM_OPS:
  - opcode_q<=opcode
  - q<=MAP_BASE+opcode*MAP_STRIDE, computed at width N+OPCODE_BITS and truncated to N
  - step<=0, dispatch<=1 next cycle
- load with opcode >= NUM_OPS:
  - q<=TRAP_STATE, opcode_q<=opcode, illegal<=1 (stays set until clr)
  - step<=0, dispatch stays 0
- jmp: q<=jmp_target; step<=step+1 (saturating).
- inc: q<=q+1 modulo 2**N; 2**N-1 wraps to 0. step<=step+1 (saturating).
- No command: q holds; step<=step+1 (saturating).
- step saturates at 2**N-1 and never wraps.
- dispatch is high for exactly one cycle per legal load. Back-to-back loads produce back-to-back pulses.
- Elaboration checks (assert on violation):
  - MAP_BASE+(NUM_OPS-1)*MAP_STRIDE < 2**N
  - TRAP_STATE < 2**N
  - FETCH_START < 2**N

Test Plan:
- clr=1 for 2 cycles with load=1, opcode=2 -> q=0, opcode_q=0, step=0, dispatch=0, illegal=0 throughout.
- From reset: inc, inc (q=2), then load with opcode=4 -> q=15, opcode_q=4, dispatch=1 for one cycle, step=0. Then inc twice -> q=17, step=2. Then ret -> q=0.
- load with opcode=7 (>= NUM_OPS) -> q=31, illegal=1, dispatch=0. A later legal load with opcode=1 -> q=6 while illegal stays 1. clr -> illegal=0.
- q=31 via jmp with jmp_target=31, then inc -> q=0. Assert ret+load+inc in one cycle -> q=0 (ret wins). load+jmp with opcode=0 -> q=3 (load wins).
- load with opcode=3 (q=12), then stall=1 for 4 cycles with inc=1 and load=1 -> q=12, step=0, opcode_q=3 unchanged. Release stall with inc=1 -> q=13.
- After a dispatch, hold 40 idle cycles -> step reaches 31 and remains 31. clr during this -> step=0, q=0.

Source files
------------

// File: rtl/cu_microsequencer.sv
// Control-unit state sequencer: dispatches opcodes to execute-routine start states
// via a base/stride map, with increment, jump, return, stall, trap and a step counter.
module cu_microsequencer #(
    parameter int unsigned OPCODE_BITS = 3,
    parameter int unsigned N           = 5,
    parameter int unsigned NUM_OPS     = 6,
    parameter int unsigned FETCH_START = 0,
    parameter int unsigned MAP_BASE    = 3,
    parameter int unsigned MAP_STRIDE  = 3,
    parameter int unsigned TRAP_STATE  = 31
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [OPCODE_BITS-1:0] opcode,
    input  logic                   load,
    input  logic                   inc,
    input  logic                   jmp,
    input  logic [N-1:0]           jmp_target,
    input  logic                   ret,
    input  logic                   stall,
    output logic [N-1:0]           q,
    output logic [OPCODE_BITS-1:0] opcode_q,
    output logic [N-1:0]           step,
    output logic                   dispatch,
    output logic                   illegal
);

    localparam int unsigned MAP_W = N + OPCODE_BITS;

    // Parameter sanity: every mapped start, the trap and fetch must be encodable in q.
    if (MAP_BASE + (NUM_OPS - 1) * MAP_STRIDE >= 2 ** N) begin : g_bad_map
        $error("cu_microsequencer: opcode map exceeds state range");
    end
    if (TRAP_STATE >= 2 ** N) begin : g_bad_trap
        $error("cu_microsequencer: TRAP_STATE exceeds state range");
    end
    if (FETCH_START >= 2 ** N) begin : g_bad_fetch
        $error("cu_microsequencer: FETCH_START exceeds state range");
    end
    if (NUM_OPS > 2 ** OPCODE_BITS) begin : g_bad_ops
        $error("cu_microsequencer: NUM_OPS exceeds opcode space");
    end

    logic [N-1:0]           q_q, q_d;
    logic [OPCODE_BITS-1:0] opcode_q_q, opcode_q_d;
    logic [N-1:0]           step_q, step_d;
    logic                   dispatch_q, dispatch_d;
    logic                   illegal_q, illegal_d;

    logic [MAP_W-1:0]       map_wide_c;
    logic [N-1:0]           step_sat_c;
    logic                   op_legal_c;

    assign map_wide_c = MAP_W'(MAP_BASE) + MAP_W'(opcode) * MAP_W'(MAP_STRIDE);
    assign step_sat_c = (step_q == {N{1'b1}}) ? step_q : step_q + N'(1);
    assign op_legal_c = 32'(opcode) < NUM_OPS;

    // Next-state: stall freezes everything, otherwise ret > load > jmp > inc > hold.
    always_comb begin
        q_d        = q_q;
        opcode_q_d = opcode_q_q;
        step_d     = step_q;
        dispatch_d = 1'b0;
        illegal_d  = illegal_q;

        if (!stall) begin
            step_d = step_sat_c;
            if (ret) begin
                q_d = N'(FETCH_START);
            end else if (load) begin
                opcode_q_d = opcode;
                step_d     = '0;
                if (op_legal_c) begin
                    q_d        = map_wide_c[N-1:0];
                    dispatch_d = 1'b1;
                end else begin
                    q_d       = N'(TRAP_STATE);
                    illegal_d = 1'b1;
                end
            end else if (jmp) begin
                q_d = jmp_target;
            end else if (inc) begin
                q_d = q_q + N'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q        <= N'(FETCH_START);
            opcode_q_q <= '0;
            step_q     <= '0;
            dispatch_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            q_q        <= q_d;
            opcode_q_q <= opcode_q_d;
            step_q     <= step_d;
            dispatch_q <= dispatch_d;
            illegal_q  <= illegal_d;
        end
    end

    assign q        = q_q;
    assign opcode_q = opcode_q_q;
    assign step     = step_q;
    assign dispatch = dispatch_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_cu_microsequencer.sv
// Directed bench for cu_microsequencer with default parameters and hand-computed expectations.
module tb_cu_microsequencer;

    logic       clk = 1'b0;
    logic       clr;
    logic [2:0] opcode;
    logic       load, inc, jmp, ret, stall;
    logic [4:0] jmp_target;
    logic [4:0] q;
    logic [2:0] opcode_q;
    logic [4:0] step;
    logic       dispatch, illegal;

    int n_cmp = 0;
    int n_bad = 0;

    cu_microsequencer dut (
        .clk        (clk),
        .clr        (clr),
        .opcode     (opcode),
        .load       (load),
        .inc        (inc),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .ret        (ret),
        .stall      (stall),
        .q          (q),
        .opcode_q   (opcode_q),
        .step       (step),
        .dispatch   (dispatch),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        clr = 1'b0; opcode = 3'd0; load = 1'b0; inc = 1'b0;
        jmp = 1'b0; jmp_target = 5'd0; ret = 1'b0; stall = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        clr = 1'b1; load = 1'b1; opcode = 3'd2; inc = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++; if (q !== 5'd0)        begin n_bad++; $display("FAIL reset_q cyc%0d got %0d exp 0", c, q); end
            n_cmp++; if (opcode_q !== 3'd0) begin n_bad++; $display("FAIL reset_opq cyc%0d got %0d exp 0", c, opcode_q); end
            n_cmp++; if (step !== 5'd0)     begin n_bad++; $display("FAIL reset_step cyc%0d got %0d exp 0", c, step); end
            n_cmp++; if (dispatch !== 1'b0) begin n_bad++; $display("FAIL reset_disp cyc%0d got %0b exp 0", c, dispatch); end
            n_cmp++; if (illegal !== 1'b0)  begin n_bad++; $display("FAIL reset_ill cyc%0d got %0b exp 0", c, illegal); end
        end
        idle_inputs();
    endtask

    task automatic test_dispatch();
        idle_inputs();
        inc = 1'b1; tick(); tick();
        n_cmp++; if (q !== 5'd2)    begin n_bad++; $display("FAIL inc2_q got %0d exp 2", q); end
        n_cmp++; if (step !== 5'd2) begin n_bad++; $display("FAIL inc2_step got %0d exp 2", step); end
        idle_inputs(); load = 1'b1; opcode = 3'd4; tick();
        n_cmp++; if (q !== 5'd15)       begin n_bad++; $display("FAIL load4_q got %0d exp 15", q); end
        n_cmp++; if (opcode_q !== 3'd4) begin n_bad++; $display("FAIL load4_opq got %0d exp 4", opcode_q); end
        n_cmp++; if (dispatch !== 1'b1) begin n_bad++; $display("FAIL load4_disp got %0b exp 1", dispatch); end
        n_cmp++; if (step !== 5'd0)     begin n_bad++; $display("FAIL load4_step got %0d exp 0", step); end
        idle_inputs(); inc = 1'b1; tick();
        n_cmp++; if (dispatch !== 1'b0) begin n_bad++; $display("FAIL disp_pulse got %0b exp 0", dispatch); end
        tick();
        n_cmp++; if (q !== 5'd17)    begin n_bad++; $display("FAIL inc17_q got %0d exp 17", q); end
        n_cmp++; if (step !== 5'd2)  begin n_bad++; $display("FAIL inc17_step got %0d exp 2", step); end
        idle_inputs(); ret = 1'b1; tick();
        n_cmp++; if (q !== 5'd0)     begin n_bad++; $display("FAIL ret_q got %0d exp 0", q); end
        n_cmp++; if (step !== 5'd3)  begin n_bad++; $display("FAIL ret_step got %0d exp 3", step); end
        idle_inputs();
    endtask

    task automatic test_illegal();
        idle_inputs(); load = 1'b1; opcode = 3'd7; tick();
        n_cmp++; if (q !== 5'd31)       begin n_bad++; $display("FAIL ill_q got %0d exp 31", q); end
        n_cmp++; if (illegal !== 1'b1)  begin n_bad++; $display("FAIL ill_flag got %0b exp 1", illegal); end
        n_cmp++; if (dispatch !== 1'b0) begin n_bad++; $display("FAIL ill_disp got %0b exp 0", dispatch); end
        n_cmp++; if (opcode_q !== 3'd7) begin n_bad++; $display("FAIL ill_opq got %0d exp 7", opcode_q); end
        idle_inputs(); tick();
        load = 1'b1; opcode = 3'd1; tick();
        n_cmp++; if (q !== 5'd6)        begin n_bad++; $display("FAIL legal1_q got %0d exp 6", q); end
        n_cmp++; if (illegal !== 1'b1)  begin n_bad++; $display("FAIL sticky_ill got %0b exp 1", illegal); end
        n_cmp++; if (dispatch !== 1'b1) begin n_bad++; $display("FAIL legal1_disp got %0b exp 1", dispatch); end
        idle_inputs(); clr = 1'b1; tick();
        n_cmp++; if (illegal !== 1'b0)  begin n_bad++; $display("FAIL clr_ill got %0b exp 0", illegal); end
        n_cmp++; if (q !== 5'd0)        begin n_bad++; $display("FAIL clr_q got %0d exp 0", q); end
        idle_inputs();
    endtask

    task automatic test_priority();
        idle_inputs(); jmp = 1'b1; jmp_target = 5'd31; tick();
        n_cmp++; if (q !== 5'd31) begin n_bad++; $display("FAIL jmp31_q got %0d exp 31", q); end
        idle_inputs(); inc = 1'b1; tick();
        n_cmp++; if (q !== 5'd0)  begin n_bad++; $display("FAIL wrap_q got %0d exp 0", q); end
        idle_inputs(); jmp = 1'b1; jmp_target = 5'd20; tick();
        n_cmp++; if (q !== 5'd20) begin n_bad++; $display("FAIL jmp20_q got %0d exp 20", q); end
        idle_inputs(); ret = 1'b1; load = 1'b1; inc = 1'b1; opcode = 3'd2; tick();
        n_cmp++; if (q !== 5'd0)        begin n_bad++; $display("FAIL ret_wins_q got %0d exp 0", q); end
        n_cmp++; if (dispatch !== 1'b0) begin n_bad++; $display("FAIL ret_wins_disp got %0b exp 0", dispatch); end
        idle_inputs(); load = 1'b1; jmp = 1'b1; jmp_target = 5'd9; opcode = 3'd0; tick();
        n_cmp++; if (q !== 5'd3)        begin n_bad++; $display("FAIL load_wins_q got %0d exp 3", q); end
        n_cmp++; if (dispatch !== 1'b1) begin n_bad++; $display("FAIL load_wins_disp got %0b exp 1", dispatch); end
        idle_inputs(); jmp = 1'b1; inc = 1'b1; jmp_target = 5'd9; tick();
        n_cmp++; if (q !== 5'd9)        begin n_bad++; $display("FAIL jmp_wins_q got %0d exp 9", q); end
        idle_inputs();
    endtask

    task automatic test_stall();
        idle_inputs(); load = 1'b1; opcode = 3'd3; tick();
        n_cmp++; if (q !== 5'd12) begin n_bad++; $display("FAIL load3_q got %0d exp 12", q); end
        stall = 1'b1; inc = 1'b1; load = 1'b1; opcode = 3'd5;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++; if (q !== 5'd12)       begin n_bad++; $display("FAIL stall_q cyc%0d got %0d exp 12", c, q); end
            n_cmp++; if (step !== 5'd0)     begin n_bad++; $display("FAIL stall_step cyc%0d got %0d exp 0", c, step); end
            n_cmp++; if (opcode_q !== 3'd3) begin n_bad++; $display("FAIL stall_opq cyc%0d got %0d exp 3", c, opcode_q); end
            n_cmp++; if (dispatch !== 1'b0) begin n_bad++; $display("FAIL stall_disp cyc%0d got %0b exp 0", c, dispatch); end
        end
        idle_inputs(); inc = 1'b1; tick();
        n_cmp++; if (q !== 5'd13)    begin n_bad++; $display("FAIL unstall_q got %0d exp 13", q); end
        n_cmp++; if (step !== 5'd1)  begin n_bad++; $display("FAIL unstall_step got %0d exp 1", step); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        idle_inputs(); load = 1'b1; opcode = 3'd1; tick();
        n_cmp++; if (q !== 5'd6)        begin n_bad++; $display("FAIL b2b1_q got %0d exp 6", q); end
        n_cmp++; if (dispatch !== 1'b1) begin n_bad++; $display("FAIL b2b1_disp got %0b exp 1", dispatch); end
        opcode = 3'd2; tick();
        n_cmp++; if (q !== 5'd9)        begin n_bad++; $display("FAIL b2b2_q got %0d exp 9", q); end
        n_cmp++; if (dispatch !== 1'b1) begin n_bad++; $display("FAIL b2b2_disp got %0b exp 1", dispatch); end
        n_cmp++; if (opcode_q !== 3'd2) begin n_bad++; $display("FAIL b2b2_opq got %0d exp 2", opcode_q); end
        opcode = 3'd5; tick();
        n_cmp++; if (q !== 5'd18)       begin n_bad++; $display("FAIL b2b5_q got %0d exp 18", q); end
        idle_inputs(); tick();
        n_cmp++; if (dispatch !== 1'b0) begin n_bad++; $display("FAIL b2b_end_disp got %0b exp 0", dispatch); end
        idle_inputs();
    endtask

    task automatic test_step_sat();
        idle_inputs(); load = 1'b1; opcode = 3'd0; tick();
        n_cmp++; if (step !== 5'd0) begin n_bad++; $display("FAIL sat_start got %0d exp 0", step); end
        idle_inputs();
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 30 || c == 31 || c == 32 || c == 40) begin
                n_cmp++;
                if (step !== 5'((c < 31) ? c : 31)) begin
                    n_bad++; $display("FAIL sat_step cyc%0d got %0d exp %0d", c, step, (c < 31) ? c : 31);
                end
            end
        end
        n_cmp++; if (q !== 5'd3) begin n_bad++; $display("FAIL sat_q got %0d exp 3", q); end
        clr = 1'b1; tick();
        n_cmp++; if (step !== 5'd0) begin n_bad++; $display("FAIL sat_clr_step got %0d exp 0", step); end
        n_cmp++; if (q !== 5'd0)    begin n_bad++; $display("FAIL sat_clr_q got %0d exp 0", q); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_dispatch();
        test_illegal();
        test_priority();
        test_stall();
        test_back_to_back();
        test_step_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
